// File: rtl/memory_pkg.sv
// Shared constants for the byte-addressed memory: write-length encodings and default depth.
package memory_pkg;

  localparam logic [2:0] WL_BYTE = 3'd0;
  localparam logic [2:0] WL_HALF = 3'd1;
  localparam logic [2:0] WL_WORD = 3'd2;

  localparam int unsigned MEM_DEPTH_DEFAULT = 4096;

endpackage

// File: rtl/memory_lane_decode.sv
// Maps a write request and its size to the four byte-lane write enables (lane 0 = byte at address).
module memory_lane_decode
  import memory_pkg::*;
(
  input  logic       wr_enable,
  input  logic [2:0] write_length,
  output logic [3:0] lane_we
);

  always_comb begin
    lane_we = 4'b0000;
    if (wr_enable) begin
      case (write_length)
        WL_BYTE: lane_we = 4'b0001;
        WL_HALF: lane_we = 4'b0011;
        WL_WORD: lane_we = 4'b1111;
        default: lane_we = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/memory.sv
// Byte-addressed little-endian memory with asynchronous 4-byte read and byte/half/word writes.
// Optional macro MEMORY_ADDR_CHECK_EN adds addr_err and disables wrap-around accesses.
module memory
  import memory_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = MEM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] wr_data,
  input  logic        wr_enable,
  input  logic [2:0]  write_length,
  output logic [31:0] read_data
`ifdef MEMORY_ADDR_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]    mem_q [DEPTH_BYTES];
  logic [AW-1:0] lane_idx [4];
  logic [7:0]    lane_wdata [4];
  logic [3:0]    lane_we_raw;
  logic [3:0]    lane_we;
  logic          unused_addr_hi;

  memory_lane_decode u_lane_decode (
    .wr_enable    (wr_enable),
    .write_length (write_length),
    .lane_we      (lane_we_raw)
  );

  // Truncating address+k to AW bits gives the modulo-DEPTH wrap for free.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_idx[k]   = address[AW-1:0] + AW'(k);
      lane_wdata[k] = wr_data[8*k +: 8];
    end
  end

  assign unused_addr_hi = ^address[31:AW];

`ifdef MEMORY_ADDR_CHECK_EN
  logic [32:0] last_byte;

  assign last_byte = {1'b0, address} + 33'd3;
  assign addr_err  = (last_byte >= 33'(DEPTH_BYTES));
  assign lane_we   = addr_err ? 4'b0000 : lane_we_raw;
`else
  assign lane_we   = lane_we_raw;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_BYTES; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (lane_we[k]) begin
          mem_q[lane_idx[k]] <= lane_wdata[k];
        end
      end
    end
  end

  always_comb begin
    read_data = {mem_q[lane_idx[3]], mem_q[lane_idx[2]], mem_q[lane_idx[1]], mem_q[lane_idx[0]]};
`ifdef MEMORY_ADDR_CHECK_EN
    if (addr_err) begin
      read_data = 32'h0000_0000;
    end
`endif
  end

endmodule

// File: tb/tb_memory.sv
// Directed self-checking bench for memory; covers writes of each size, wrap/limit at the top, and reset.
module tb_memory;
  import memory_pkg::*;

  localparam int unsigned DEPTH = MEM_DEPTH_DEFAULT;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic        wr_enable;
  logic [2:0]  write_length;
  logic [31:0] read_data;
`ifdef MEMORY_ADDR_CHECK_EN
  logic        addr_err;
`endif

  int n_compared;
  int n_mismatched;

  memory #(.DEPTH_BYTES(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .wr_data      (wr_data),
    .wr_enable    (wr_enable),
    .write_length (write_length),
    .read_data    (read_data)
`ifdef MEMORY_ADDR_CHECK_EN
    ,
    .addr_err     (addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then return 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rst, input logic we, input logic [31:0] addr,
                               input logic [31:0] data, input logic [2:0] wl);
    @(negedge clk);
    reset        = rst;
    wr_enable    = we;
    address      = addr;
    wr_data      = data;
    write_length = wl;
    @(posedge clk);
    #1;
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] expected);
    @(negedge clk);
    reset     = 1'b0;
    wr_enable = 1'b0;
    address   = addr;
    #1;
    checkOutput(tag, read_data, expected);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b1;
    wr_enable    = 1'b0;
    address      = '0;
    wr_data      = '0;
    write_length = WL_BYTE;

    applyStimulus(1'b1, 1'b1, 32'd0, 32'hFFFF_FFFF, WL_WORD);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'h0, WL_BYTE);
    readCheck("reset_addr0", 32'd0, 32'h0000_0000);
    readCheck("reset_addr40", 32'd40, 32'h0000_0000);

    applyStimulus(1'b0, 1'b0, 32'd0, 32'h89AB_CDEF, WL_HALF);
    checkOutput("wr_disabled", read_data, 32'h0000_0000);

    @(negedge clk);
    reset        = 1'b0;
    wr_enable    = 1'b1;
    address      = 32'd5;
    wr_data      = 32'h1234_5678;
    write_length = WL_WORD;
    #1;
    checkOutput("word_before_edge", read_data, 32'h0000_0000);
    @(posedge clk);
    #1;
    checkOutput("word_after_edge", read_data, 32'h1234_5678);
    readCheck("word_unaligned_a4", 32'd4, 32'h3456_7800);
    readCheck("word_unaligned_a8", 32'd8, 32'h0000_0012);

    applyStimulus(1'b0, 1'b1, 32'd4, 32'h12AB_CDEF, WL_BYTE);
    applyStimulus(1'b0, 1'b1, 32'd5, 32'h34FB_DEAD, WL_BYTE);
    applyStimulus(1'b0, 1'b1, 32'd6, 32'h56ED_FABD, WL_BYTE);
    applyStimulus(1'b0, 1'b1, 32'd7, 32'h78AD_EFAB, WL_BYTE);
    readCheck("byte_writes", 32'd4, 32'hABBD_ADEF);
    readCheck("byte_neighbour", 32'd8, 32'h0000_0012);

    applyStimulus(1'b0, 1'b1, 32'd36, 32'h1234_ABCD, WL_WORD);
    applyStimulus(1'b0, 1'b1, 32'd36, 32'h5678_EFDA, WL_HALF);
    readCheck("half_write", 32'd36, 32'h1234_EFDA);

    applyStimulus(1'b0, 1'b1, 32'd36, 32'hFFFF_FFFF, 3'd3);
    applyStimulus(1'b0, 1'b1, 32'd36, 32'hFFFF_FFFF, 3'd7);
    readCheck("wl_invalid", 32'd36, 32'h1234_EFDA);

    applyStimulus(1'b0, 1'b1, 32'd37, 32'h0000_BEEF, WL_HALF);
    readCheck("half_unaligned", 32'd36, 32'h12BE_EFDA);

    applyStimulus(1'b0, 1'b1, 32'd8, 32'hDEAD_BEEF, WL_WORD);
    readCheck("pre_reset_word", 32'd8, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b1, 32'd8, 32'h1111_1111, WL_WORD);
    readCheck("reset_wins_a8", 32'd8, 32'h0000_0000);
    readCheck("reset_clears_a4", 32'd4, 32'h0000_0000);
    readCheck("reset_clears_a36", 32'd36, 32'h0000_0000);

    applyStimulus(1'b0, 1'b1, 32'd100, 32'h0000_00AA, WL_BYTE);
    applyStimulus(1'b1, 1'b0, 32'd0, 32'h0, WL_BYTE);
    applyStimulus(1'b0, 1'b1, 32'd101, 32'h0000_00BB, WL_BYTE);
    readCheck("reset_between", 32'd100, 32'h0000_BB00);

    applyStimulus(1'b0, 1'b1, DEPTH - 2, 32'hCAFE_F00D, WL_WORD);
`ifdef MEMORY_ADDR_CHECK_EN
    readCheck("top_read_zero", DEPTH - 2, 32'h0000_0000);
    checkOutput("top_addr_err", {31'd0, addr_err}, 32'd1);
    readCheck("top_no_wrap_write", 32'd0, 32'h0000_0000);
    checkOutput("low_addr_err", {31'd0, addr_err}, 32'd0);
    readCheck("top_last_valid", DEPTH - 4, 32'h0000_0000);
`else
    readCheck("top_wrap_a0", 32'd0, 32'h0000_CAFE);
    readCheck("top_wrap_read", DEPTH - 2, 32'hCAFE_F00D);
    applyStimulus(1'b0, 1'b1, DEPTH - 1, 32'h0000_0077, WL_BYTE);
    readCheck("top_byte_last", DEPTH - 1, 32'h00CA_FE77);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
